// File: rtl/i2c_slave_regmap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regmap
// Description : I2C slave with an internal register file, 7-bit address match,
//               auto-incrementing register pointer and repeated-START support.
//               A local synchronous port reads/writes the same register file.
// Ports       : clk, rst_n (async, active low)
//               scl_in, sda_in   - asynchronous pad inputs
//               sda_oen          - 0 pulls SDA low, 1 releases it
//               lcl_we/lcl_addr/lcl_wdata/lcl_rdata - local register port
//               i2c_wr_vld/i2c_wr_addr - notification of an I2C register write
//               hitar, flag_start, flag_stop, flag_ack - bus status
// Config      : `define I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority
//               filter on the synchronized SCL/SDA (2 extra cycles latency).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regmap #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  parameter int         DW         = 8,
  localparam int        AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oen,
  input  logic          lcl_we,
  input  logic [AW-1:0] lcl_addr,
  input  logic [DW-1:0] lcl_wdata,
  output logic [DW-1:0] lcl_rdata,
  output logic          i2c_wr_vld,
  output logic [AW-1:0] i2c_wr_addr,
  output logic          hitar,
  output logic          flag_start,
  output logic          flag_stop,
  output logic          flag_ack
);

  localparam logic [3:0] c_ST_IDLE     = 4'd0;
  localparam logic [3:0] c_ST_ADDR     = 4'd1;
  localparam logic [3:0] c_ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] c_ST_PTR      = 4'd3;
  localparam logic [3:0] c_ST_PTR_ACK  = 4'd4;
  localparam logic [3:0] c_ST_WDATA    = 4'd5;
  localparam logic [3:0] c_ST_W_ACK    = 4'd6;
  localparam logic [3:0] c_ST_RDATA    = 4'd7;
  localparam logic [3:0] c_ST_R_ACK    = 4'd8;
  localparam logic [3:0] c_ST_IGNORE   = 4'd9;

  // Input conditioning. Synchronizers reset to 1 (idle bus) so reset
  // release never produces a spurious edge.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       w_scl, w_sda;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  // Majority of the current and two previous synchronized samples; a
  // single-sample pulse can never win the vote.
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_flt_q  <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                    (scl_hist_q[0] & scl_hist_q[1]);
      sda_flt_q  <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                    (sda_hist_q[0] & sda_hist_q[1]);
    end
  end

  assign w_scl = scl_flt_q;
  assign w_sda = sda_flt_q;
`else
  assign w_scl = scl_sync_q[1];
  assign w_sda = sda_sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= w_scl;
      sda_prev_q <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~scl_prev_q;
  assign w_scl_fall = ~w_scl & scl_prev_q;
  // SCL must be high in both samples so an SDA change never coincides with an SCL edge.
  assign w_start    = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
  assign w_stop     = w_scl & scl_prev_q & ~sda_prev_q & w_sda;

  // Protocol state
  logic [3:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          oen_q, oen_d;
  logic          hitar_q, hitar_d;
  logic          rw_q, rw_d;
  logic          ackph_q, ackph_d;   // ACK slot: 0 = before its SCL low phase, 1 = inside it
  logic          start_q, start_d, stop_q, stop_d, ack_q, ack_d, wr_vld_q, wr_vld_d;
  logic          w_i2c_we;

  logic [DW-1:0] regs_q [DEPTH];
  logic [DW-1:0] lcl_rdata_q;
  logic [DW-1:0] w_byte, w_rd_byte;

  assign w_byte    = {shreg_q[DW-2:0], w_sda};
  assign w_rd_byte = regs_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    oen_d     = oen_q;
    hitar_d   = hitar_q;
    rw_d      = rw_q;
    ackph_d   = ackph_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    ack_d     = 1'b0;
    wr_vld_d  = 1'b0;
    w_i2c_we  = 1'b0;

    if (w_start) begin
      state_d  = c_ST_ADDR;
      bitcnt_d = 3'd0;
      ackph_d  = 1'b0;
      hitar_d  = 1'b0;
      oen_d    = 1'b1;
      start_d  = 1'b1;
    end else if (w_stop) begin
      state_d = c_ST_IDLE;
      hitar_d = 1'b0;
      oen_d   = 1'b1;
      stop_d  = 1'b1;
    end else if (w_scl_rise) begin
      case (state_q)
        c_ST_ADDR, c_ST_PTR, c_ST_WDATA: begin
          shreg_d  = w_byte;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            ackph_d = 1'b0;
            if (state_q == c_ST_ADDR) begin
              if (w_byte[DW-1:1] == SLAVE_ADDR) begin
                state_d = c_ST_ADDR_ACK;
                rw_d    = w_byte[0];
              end else begin
                state_d = c_ST_IGNORE;
              end
            end else if (state_q == c_ST_PTR) begin
              ptr_d   = w_byte[AW-1:0];
              state_d = c_ST_PTR_ACK;
            end else begin
              w_i2c_we  = 1'b1;
              wr_vld_d  = 1'b1;
              wr_addr_d = ptr_q;
              ptr_d     = ptr_q + AW'(1);
              state_d   = c_ST_W_ACK;
            end
          end
        end
        c_ST_RDATA: begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = c_ST_R_ACK;
            ackph_d = 1'b0;
          end
        end
        // Master NACK ends the read; SDA is already released.
        c_ST_R_ACK: if (ackph_q && w_sda) state_d = c_ST_IGNORE;
        default: ;
      endcase
    end else if (w_scl_fall) begin
      case (state_q)
        c_ST_ADDR_ACK, c_ST_PTR_ACK, c_ST_W_ACK: begin
          if (!ackph_q) begin
            oen_d   = 1'b0;
            ackph_d = 1'b1;
            ack_d   = 1'b1;
            if (state_q == c_ST_ADDR_ACK) hitar_d = 1'b1;
          end else begin
            ackph_d  = 1'b0;
            bitcnt_d = 3'd0;
            if (state_q == c_ST_ADDR_ACK && rw_q) begin
              shreg_d = w_rd_byte;
              oen_d   = w_rd_byte[DW-1];
              ptr_d   = ptr_q + AW'(1);
              state_d = c_ST_RDATA;
            end else begin
              oen_d   = 1'b1;
              state_d = (state_q == c_ST_ADDR_ACK) ? c_ST_PTR : c_ST_WDATA;
            end
          end
        end
        c_ST_RDATA: begin
          oen_d   = shreg_q[DW-2];
          shreg_d = {shreg_q[DW-2:0], 1'b0};
        end
        c_ST_R_ACK: begin
          if (!ackph_q) begin
            oen_d   = 1'b1;
            ackph_d = 1'b1;
          end else begin
            shreg_d  = w_rd_byte;
            oen_d    = w_rd_byte[DW-1];
            ptr_d    = ptr_q + AW'(1);
            bitcnt_d = 3'd0;
            ackph_d  = 1'b0;
            state_d  = c_ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_ST_IDLE;
      bitcnt_q  <= 3'd0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      oen_q     <= 1'b1;
      hitar_q   <= 1'b0;
      rw_q      <= 1'b0;
      ackph_q   <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      ack_q     <= 1'b0;
      wr_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      oen_q     <= oen_d;
      hitar_q   <= hitar_d;
      rw_q      <= rw_d;
      ackph_q   <= ackph_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      ack_q     <= ack_d;
      wr_vld_q  <= wr_vld_d;
    end
  end

  // Register file. The I2C write is issued last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      lcl_rdata_q <= '0;
    end else begin
      if (lcl_we)   regs_q[lcl_addr] <= lcl_wdata;
      if (w_i2c_we) regs_q[ptr_q]    <= w_byte;
      lcl_rdata_q <= regs_q[lcl_addr];
    end
  end

  assign sda_oen     = oen_q;
  assign lcl_rdata   = lcl_rdata_q;
  assign i2c_wr_vld  = wr_vld_q;
  assign i2c_wr_addr = wr_addr_q;
  assign hitar       = hitar_q;
  assign flag_start  = start_q;
  assign flag_stop   = stop_q;
  assign flag_ack    = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regmap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_regmap
// Description : Self-checking bench for i2c_slave_regmap: bit-level I2C master,
//               transaction-level reference model and scoreboard monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regmap;

  localparam logic [6:0] SLV   = 7'h50;
  localparam int         DEPTH = 16;
  localparam int         AW    = 4;
  localparam int         QTR   = 10;
`ifdef I2C_SLV_GLITCH_FILTER_EN
  localparam int         SYNC_LAT = 4;
`else
  localparam int         SYNC_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic          lcl_we = 1'b0;
  logic [AW-1:0] lcl_addr = '0;
  logic [7:0]    lcl_wdata = '0;
  logic          sda_oen, i2c_wr_vld, hitar, flag_start, flag_stop, flag_ack;
  logic [7:0]    lcl_rdata;
  logic [AW-1:0] i2c_wr_addr;
  logic          sda_bus;

  assign sda_bus = m_sda & sda_oen;   // open-drain wired-AND

  always #5 clk = ~clk;

  i2c_slave_regmap #(.SLAVE_ADDR(SLV), .DEPTH(DEPTH), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(m_scl), .sda_in(sda_bus), .sda_oen(sda_oen),
    .lcl_we(lcl_we), .lcl_addr(lcl_addr), .lcl_wdata(lcl_wdata), .lcl_rdata(lcl_rdata),
    .i2c_wr_vld(i2c_wr_vld), .i2c_wr_addr(i2c_wr_addr), .hitar(hitar),
    .flag_start(flag_start), .flag_stop(flag_stop), .flag_ack(flag_ack)
  );

  // Reference model: register array, pointer and protocol phase
  // (0 idle/ignored, 1 expect address, 2 expect pointer, 3 write data, 4 read data).
  logic [7:0] mem [DEPTH];
  int mptr, mst;
  int exp_wr[$], exp_rd[$], obs_rd[$];
  int exp_ack, exp_start, exp_stop, ack_seen, start_seen, stop_seen;
  int n_chk, n_fail, mon_o;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    mptr = 0;
    mst  = 0;
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (flag_ack)   ack_seen++;
      if (flag_start) start_seen++;
      if (flag_stop)  stop_seen++;
      if (i2c_wr_vld) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else                    chk("wr_addr", 32'(i2c_wr_addr), 32'(exp_wr.pop_front()));
      end
    end
    if (obs_rd.size() > 0) begin
      mon_o = obs_rd.pop_front();
      if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else                    chk("rd_data", 32'(mon_o), 32'(exp_rd.pop_front()));
    end
  end

  // Bit-level master
  task automatic qtr();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; qtr(); m_scl = 1'b1; qtr(); qtr(); m_scl = 1'b0; qtr();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; qtr(); m_scl = 1'b1; qtr(); b = sda_bus; qtr(); m_scl = 1'b0; qtr();
  endtask

  // Last data bit with a local write aligned to the cycle the slave commits the byte.
  task automatic coll_bit(input logic b, input int la, input logic [7:0] ld);
    m_sda = b; qtr(); m_scl = 1'b1;
    repeat (SYNC_LAT) @(negedge clk);
    lcl_addr = AW'(la); lcl_wdata = ld; lcl_we = 1'b1;
    @(negedge clk);
    lcl_we = 1'b0;
    repeat (2*QTR - SYNC_LAT - 1) @(negedge clk);
    m_scl = 1'b0; qtr();
  endtask

  task automatic m_start();
    m_sda = 1'b1; qtr(); m_scl = 1'b1; qtr(); m_sda = 1'b0; qtr(); m_scl = 1'b0; qtr();
    mst = 1;
    exp_start++;
  endtask

  task automatic m_stop();
    m_sda = 1'b0; qtr(); m_scl = 1'b1; qtr(); m_sda = 1'b1; qtr(); qtr();
    mst = 0;
    exp_stop++;
  endtask

  task automatic m_wbyte(input logic [7:0] b, input bit coll = 1'b0, input int la = 0,
                         input logic [7:0] ld = 8'h00);
    logic expack, a;
    case (mst)
      1: begin
        expack = (b[7:1] == SLV);
        mst    = expack ? (b[0] ? 4 : 2) : 0;
      end
      2: begin expack = 1'b1; mptr = int'(b) % DEPTH; mst = 3; end
      3: begin
        expack = 1'b1;
        if (coll) mem[la] = ld;
        mem[mptr] = b;
        exp_wr.push_back(mptr);
        mptr = (mptr + 1) % DEPTH;
      end
      default: expack = 1'b0;
    endcase
    if (expack) exp_ack++;
    for (int i = 7; i >= 0; i--) begin
      if (coll && i == 0) coll_bit(b[i], la, ld);
      else                send_bit(b[i]);
    end
    recv_bit(a);
    chk("ack_bit", 32'(!a), 32'(expack));
  endtask

  task automatic m_rbyte(input logic ack_m);
    logic [7:0] d;
    logic       bb;
    if (mst == 4) begin
      exp_rd.push_back(int'(mem[mptr]));
      mptr = (mptr + 1) % DEPTH;
    end
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bb);
      d[i] = bb;
    end
    if (mst == 4) obs_rd.push_back(int'(d));
    send_bit(!ack_m);
    if (!ack_m) mst = 0;
  endtask

  task automatic lcl_write(input int a, input logic [7:0] d);
    @(negedge clk);
    lcl_addr = AW'(a); lcl_wdata = d; lcl_we = 1'b1;
    mem[a] = d;
    @(negedge clk);
    lcl_we = 1'b0;
  endtask

  task automatic lcl_check(input int a);
    @(negedge clk);
    lcl_addr = AW'(a);
    @(posedge clk);
    #1;
    chk("lcl_rdata", 32'(lcl_rdata), 32'(mem[a]));
  endtask

  task automatic chk_hit();
    chk("hitar", 32'(hitar), 32'(mst >= 2));
  endtask

  task automatic chk_counts();
    repeat (4) @(negedge clk);
    chk("ack_count", 32'(ack_seen), 32'(exp_ack));
    chk("start_count", 32'(start_seen), 32'(exp_start));
    chk("stop_count", 32'(stop_seen), 32'(exp_stop));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n;
    logic [7:0] a;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sda_oen", 32'(sda_oen), 32'd1);
    chk("rst_hitar", 32'(hitar), 32'd0);
    chk("rst_lcl_rdata", 32'(lcl_rdata), 32'd0);
    chk("rst_pulses", 32'({flag_start, flag_stop, flag_ack, i2c_wr_vld}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: plain write
    m_start(); m_wbyte(8'hA0); chk_hit(); m_wbyte(8'h03); m_wbyte(8'h11); m_wbyte(8'h22); m_stop();
    chk_hit();
    lcl_check(3); lcl_check(4);
    chk_counts();

    // 2: pointer write, repeated START, read with ACK then NACK
    m_start(); m_wbyte(8'hA0); m_wbyte(8'h03);
    m_start(); m_wbyte(8'hA1); chk_hit();
    m_rbyte(1'b1); m_rbyte(1'b0); m_stop();
    chk_hit();
    chk_counts();

    // 3: pointer wrap
    m_start(); m_wbyte(8'hA0); m_wbyte(8'h0F); m_wbyte(8'hAA); m_wbyte(8'hBB); m_stop();
    lcl_check(15); lcl_check(0);

    // 4: wrong address is ignored
    m_start(); m_wbyte(8'hA4); chk_hit(); m_wbyte(8'h99); m_stop();
    lcl_check(3); lcl_check(4);
    chk_counts();

    // 5: same-address and different-address local/I2C write collisions
    m_start(); m_wbyte(8'hA0); m_wbyte(8'h05);
    m_wbyte(8'hC3, 1'b1, 5, 8'h5A);
    m_wbyte(8'h77, 1'b1, 9, 8'h3C);
    m_stop();
    lcl_check(5); lcl_check(9); lcl_check(6);

    // 6: reset during a read data bit
    m_start(); m_wbyte(8'hA0); m_wbyte(8'h03);
    m_start(); m_wbyte(8'hA1);
    chk("oen_read_bit7", 32'(sda_oen), 32'(mem[3][7]));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("oen_async_reset", 32'(sda_oen), 32'd1);
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    m_stop();
    m_start(); m_wbyte(8'hA0); m_wbyte(8'h07); m_wbyte(8'h5E); m_stop();
    m_start(); m_wbyte(8'hA0); m_wbyte(8'h07);
    m_start(); m_wbyte(8'hA1); m_rbyte(1'b0); m_stop();
    lcl_check(3);
    chk_counts();

`ifdef I2C_SLV_GLITCH_FILTER_EN
    // 7: single-clock SDA glitch while SCL is high
    @(negedge clk); m_sda = 1'b0;
    @(negedge clk); m_sda = 1'b1;
    repeat (12) @(negedge clk);
    chk_counts();
`endif

    // Randomized traffic
    for (int it = 0; it < 14; it++) begin
      kind = int'($urandom_range(0, 3));
      if (kind <= 1) begin
        a = ($urandom_range(0, 7) == 0) ? 8'hA6 : 8'hA0;
        m_start(); m_wbyte(a); chk_hit();
        m_wbyte(8'($urandom_range(0, 255)));
        n = int'($urandom_range(1, 3));
        for (int j = 0; j < n; j++) m_wbyte(8'($urandom_range(0, 255)));
        m_stop();
      end else if (kind == 2) begin
        m_start(); m_wbyte(8'hA1);
        n = int'($urandom_range(1, 3));
        for (int j = 0; j < n; j++) m_rbyte(j != n - 1);
        m_stop();
      end else begin
        lcl_write(int'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)));
        lcl_check(int'($urandom_range(0, DEPTH - 1)));
      end
    end
    for (int i = 0; i < DEPTH; i++) lcl_check(i);
    chk_counts();
    repeat (4) @(negedge clk);
    chk("exp_wr_left", 32'(exp_wr.size()), 32'd0);
    chk("exp_rd_left", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
